// File: rtl/nrzi_tx_ctrl_pkg.sv
// nrzi_tx_ctrl_pkg
//   Shared definitions for the NRZI transmit controller: FSM state
//   encoding, the SYNC pattern and the default parameter values.
//   No ports (package).
package nrzi_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP,
        ST_TAIL
    } state_t;

    // Sent LSB first: seven 0s then a 1.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    localparam int DEFAULT_STUFF_LIMIT = 6;
    localparam int DEFAULT_EOP_LOW     = 2;

endpackage

// File: rtl/nrzi_tx_ctrl_if.sv
// nrzi_tx_ctrl_if
//   Payload-side bundle of the NRZI transmit controller.
//   start       packet request (producer -> controller)
//   data_in     payload byte, LSB first (producer -> controller)
//   data_valid  data_in/data_last valid (producer -> controller)
//   data_last   current byte is the final one (producer -> controller)
//   data_ready  byte taken when data_valid && data_ready (controller -> producer)
//   busy        controller not idle (controller -> producer)
//   done        one-cycle pulse after a good packet (controller -> producer)
//   err         one-cycle pulse after an underrun abort (controller -> producer)
interface nrzi_tx_ctrl_if;

    logic       start;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, data_in, data_valid, data_last,
        input  data_ready, busy, done, err
    );

    modport slave (
        input  start, data_in, data_valid, data_last,
        output data_ready, busy, done, err
    );

endinterface

// File: rtl/nrzi_bit_enc.sv
// nrzi_bit_enc
//   Registered NRZI line level. A 0 on bit_in toggles the line, a 1 holds
//   it; force_low overrides NRZI and drives the line to 0.
//   clock      rising-edge clock
//   reset      asynchronous, active-high; level returns to 1 (idle)
//   bit_in     encoder input bit for this cycle
//   enable     bit_in is meaningful this cycle
//   force_low  drive the line low regardless of bit_in
//   level      line level
module nrzi_bit_enc (
    input  logic clock,
    input  logic reset,
    input  logic bit_in,
    input  logic enable,
    input  logic force_low,
    output logic level
);

    // NOTE: flops use non-blocking assignments so every register in the
    // design samples values from before the edge, independent of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= 1'b1;
        end else if (force_low) begin
            level <= 1'b0;
        end else if (enable && !bit_in) begin
            level <= ~level;
        end
    end

endmodule

// File: rtl/nrzi_tx_ctrl.sv
// nrzi_tx_ctrl
//   NRZI packet transmitter: SYNC byte, bit-stuffed payload fetched one
//   byte at a time, EOP low period and a one-cycle high tail.
//   clock     rising-edge clock
//   reset     asynchronous, active-high
//   bus       payload handshake and status (slave side of nrzi_tx_ctrl_if)
//   line_out  registered NRZI line level
//   line_oe   line driver enable
module nrzi_tx_ctrl
    import nrzi_tx_ctrl_pkg::*;
#(
    parameter int STUFF_LIMIT = DEFAULT_STUFF_LIMIT,
    parameter int EOP_LOW     = DEFAULT_EOP_LOW
) (
    input  logic           clock,
    input  logic           reset,
    nrzi_tx_ctrl_if.slave  bus,
    output logic           line_out,
    output logic           line_oe
);

    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam int EOP_W  = (EOP_LOW > 1) ? $clog2(EOP_LOW) : 1;
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);
    localparam logic [EOP_W-1:0]  EOP_LAST = EOP_W'(EOP_LOW - 1);

    state_t            state, next_state;
    logic [2:0]        bit_idx;
    logic [ONES_W-1:0] ones;
    logic [ONES_W-1:0] ones_inc;
    logic [7:0]        hold;
    logic              hold_last;
    logic              pend_load;   // pending STUFF closes a byte (SYNC or DATA bit 7)
    logic              abort;
    logic [EOP_W-1:0]  eop_cnt;
    logic              done_q, err_q, oe_q;

    logic cur_bit, byte_end, stuff_due, req_byte;
    logic enc_bit, enc_en, enc_force_low;
    logic data_ready, xfer, underrun, accept;

    assign ones_inc = ones + ONES_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        next_state    = state;
        cur_bit       = 1'b1;
        byte_end      = 1'b0;
        stuff_due     = 1'b0;
        req_byte      = 1'b0;
        enc_bit       = 1'b1;
        enc_en        = 1'b0;
        enc_force_low = 1'b0;
        data_ready    = 1'b0;
        xfer          = 1'b0;
        underrun      = 1'b0;
        accept        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = ST_SYNC;
                end
            end
            ST_SYNC, ST_DATA: begin
                cur_bit   = (state == ST_SYNC) ? SYNC_PATTERN[bit_idx] : hold[bit_idx];
                enc_bit   = cur_bit;
                enc_en    = 1'b1;
                byte_end  = (bit_idx == 3'd7);
                stuff_due = cur_bit && (ones_inc == ONES_MAX);
                if (stuff_due) begin
                    next_state = ST_STUFF;
                end else if (byte_end) begin
                    // hold_last is cleared on start, so SYNC always asks for a byte.
                    if (hold_last) next_state = ST_EOP;
                    else           req_byte   = 1'b1;
                end
            end
            ST_STUFF: begin
                enc_bit = 1'b0;
                enc_en  = 1'b1;
                if (!pend_load)     next_state = ST_DATA;
                else if (hold_last) next_state = ST_EOP;
                else                req_byte   = 1'b1;
            end
            ST_EOP: begin
                enc_force_low = 1'b1;
                if (eop_cnt == EOP_LAST) next_state = ST_TAIL;
            end
            ST_TAIL: begin
                // EOP leaves the line at 0, so a toggle brings it back to idle high.
                enc_bit    = 1'b0;
                enc_en     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase

        if (req_byte) begin
            data_ready = 1'b1;
            if (bus.data_valid) begin
                xfer       = 1'b1;
                next_state = ST_DATA;
            end else begin
                underrun   = 1'b1;
                next_state = ST_EOP;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_idx   <= '0;
            ones      <= '0;
            // NOTE: the hold byte is reset together with the control state so
            // no stale byte or last flag survives a reset.
            hold      <= '0;
            hold_last <= 1'b0;
            pend_load <= 1'b0;
            abort     <= 1'b0;
            eop_cnt   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            oe_q    <= (next_state != ST_IDLE);
            done_q  <= (state == ST_TAIL) && !abort;
            err_q   <= underrun;
            eop_cnt <= (state == ST_EOP) ? eop_cnt + EOP_W'(1) : '0;

            if (state == ST_SYNC || state == ST_DATA) begin
                bit_idx   <= bit_idx + 3'd1;   // wraps to 0 after bit 7
                ones      <= cur_bit ? ones_inc : '0;
                pend_load <= byte_end;
            end else begin
                ones <= '0;
                // A stuffed bit does not consume a data bit.
                if (state != ST_STUFF) bit_idx <= '0;
            end

            if (accept) begin
                hold_last <= 1'b0;
                abort     <= 1'b0;
            end
            if (xfer) begin
                hold      <= bus.data_in;
                hold_last <= bus.data_last;
            end
            if (underrun) begin
                abort <= 1'b1;
            end
        end
    end

    assign bus.data_ready = data_ready;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign line_oe        = oe_q;

    nrzi_bit_enc u_enc (
        .clock     (clock),
        .reset     (reset),
        .bit_in    (enc_bit),
        .enable    (enc_en),
        .force_low (enc_force_low),
        .level     (line_out)
    );

endmodule

// File: tb/tb_nrzi_tx_ctrl.sv
// tb_nrzi_tx_ctrl
//   Self-checking bench for nrzi_tx_ctrl. A packet model builds the
//   encoder bit stream (SYNC + payload, stuffed by a running ones count),
//   the data_ready cycles and the NRZI line waveform; one compare process
//   checks every DUT output against it on each cycle.
module tb_nrzi_tx_ctrl;

    localparam int LIMIT = 6;
    localparam int EOPN  = 2;

    logic clock = 1'b0;
    logic reset;
    logic line_out, line_oe;

    nrzi_tx_ctrl_if bus_if ();

    nrzi_tx_ctrl #(
        .STUFF_LIMIT (LIMIT),
        .EOP_LOW     (EOPN)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_if),
        .line_out (line_out),
        .line_oe  (line_oe)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic chk_en = 1'b0;
    logic exp_line, exp_oe, exp_busy, exp_ready, exp_done, exp_err;
    logic pending_done = 1'b0;
    int   rdy_seen, err_seen, done_seen;

    logic [7:0] pkt_q[$];
    int         m_es[$];    // encoder bits of cycles 1..m_len
    int         m_rdy[$];   // packet-relative cycles with data_ready high
    logic       m_line[$];  // line level seen in cycles 0..m_end
    int         m_len, m_end;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model. withhold >= 0 means that byte is never offered (underrun).
    task automatic build_model(input int withhold);
        int         run, n, nchunks;
        logic [7:0] b;
        logic       lvl;
        m_es.delete();
        m_rdy.delete();
        m_line.delete();
        n       = pkt_q.size();
        nchunks = (withhold >= 0) ? withhold + 1 : n + 1;
        run     = 0;
        for (int c = 0; c < nchunks; c++) begin
            b = (c == 0) ? 8'h80 : pkt_q[c-1];
            for (int i = 0; i < 8; i++) begin
                m_es.push_back(int'(b[i]));
                if (b[i]) begin
                    run++;
                    if (run == LIMIT) begin
                        m_es.push_back(0);
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
            end
            // The last bit of a chunk (stuff included) asks for the next byte.
            if (withhold >= 0 || c < nchunks - 1) m_rdy.push_back(m_es.size());
        end
        m_len = m_es.size();
        m_end = m_len + EOPN + 2;
        lvl   = 1'b1;
        m_line.push_back(1'b1);
        m_line.push_back(1'b1);
        for (int u = 1; u <= m_len; u++) begin
            if (m_es[u-1] == 0) lvl = ~lvl;
            m_line.push_back(lvl);
        end
        for (int u = 0; u < EOPN; u++) m_line.push_back(1'b0);
        m_line.push_back(1'b1);
    endtask

    task automatic drive_junk();
        bus_if.data_valid = 1'($urandom_range(1));
        bus_if.data_in    = 8'($urandom);
        bus_if.data_last  = 1'($urandom_range(1));
    endtask

    // Drives packet cycles 0..m_end-1 (cycle 0 = IDLE with start high).
    // cut >= 0 returns at the start of that cycle without driving it.
    task automatic run_packet(input int withhold, input bit start_hold,
                              input int cut, input bit skip_wait);
        int k, n;
        bit r;
        n = pkt_q.size();
        build_model(withhold);
        k = 0;
        for (int t = 0; t < m_end; t++) begin
            if (!(skip_wait && t == 0)) begin
                @(posedge clock);
                #1;
            end
            if (t == cut) return;
            bus_if.start = (t == 0) ? 1'b1 : (start_hold ? 1'b1 : 1'($urandom_range(1)));
            r = 1'b0;
            if (k < m_rdy.size() && t == m_rdy[k]) begin
                r = 1'b1;
                bus_if.data_valid = (k != withhold);
                bus_if.data_in    = (k < n) ? pkt_q[k] : 8'($urandom);
                bus_if.data_last  = (k == n - 1);
                k++;
            end else begin
                drive_junk();
            end
            exp_line  = m_line[t];
            exp_oe    = (t >= 1);
            exp_busy  = (t >= 1);
            exp_ready = r;
            exp_err   = (withhold >= 0) && (t == m_len + 1);
            exp_done  = (t == 0) ? pending_done : 1'b0;
            if (t == 0) pending_done = 1'b0;
            chk_en = 1'b1;
        end
        pending_done = (withhold < 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            bus_if.start = 1'b0;
            drive_junk();
            exp_line     = 1'b1;
            exp_oe       = 1'b0;
            exp_busy     = 1'b0;
            exp_ready    = 1'b0;
            exp_err      = 1'b0;
            exp_done     = pending_done;
            pending_done = 1'b0;
            chk_en       = 1'b1;
        end
    endtask

    task automatic clear_counts();
        rdy_seen  = 0;
        err_seen  = 0;
        done_seen = 0;
    endtask

    // Single compare process, mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check_bit("line_out",   line_out,          exp_line);
                check_bit("line_oe",    line_oe,           exp_oe);
                check_bit("busy",       bus_if.busy,       exp_busy);
                check_bit("data_ready", bus_if.data_ready, exp_ready);
                check_bit("done",       bus_if.done,       exp_done);
                check_bit("err",        bus_if.err,        exp_err);
                if (bus_if.data_ready === 1'b1) rdy_seen++;
                if (bus_if.err === 1'b1)        err_seen++;
                if (bus_if.done === 1'b1)       done_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int n, wh, gap;
        reset             = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.data_valid = 1'b0;
        bus_if.data_in    = 8'h00;
        bus_if.data_last  = 1'b0;
        clear_counts();
        repeat (3) @(posedge clock);
        #1;
        check_bit("rst_line_out",   line_out,          1'b1);
        check_bit("rst_line_oe",    line_oe,           1'b0);
        check_bit("rst_busy",       bus_if.busy,       1'b0);
        check_bit("rst_data_ready", bus_if.data_ready, 1'b0);
        check_bit("rst_done",       bus_if.done,       1'b0);
        check_bit("rst_err",        bus_if.err,        1'b0);
        #2;
        reset = 1'b0;

        // One 8'h00 byte, started on the first edge after reset release.
        pkt_q = '{8'h00};
        run_packet(-1, 1'b0, -1, 1'b1);
        idle_cycles(2);
        check_int("m00_len",        m_len,        16);
        check_int("m00_done_cycle", m_end,        20);
        check_int("m00_rdy_cycle",  m_rdy[0],     8);
        check_bit("m00_line_sync1", m_line[9],    1'b0);
        check_bit("m00_line_eop",   m_line[19],   1'b0);
        check_int("p00_ready_cnt",  rdy_seen,     1);
        check_int("p00_done_cnt",   done_seen,    1);

        // 8'hFF: stuff after data bit 4, none after bits 5..7.
        clear_counts();
        pkt_q = '{8'hFF};
        run_packet(-1, 1'b0, -1, 1'b0);
        idle_cycles(2);
        check_int("mff_data_cycles", m_len - 8, 9);
        check_int("mff_bit4",        m_es[12],  1);
        check_int("mff_stuff",       m_es[13],  0);
        check_int("pff_done_cnt",    done_seen, 1);

        // 8'h3F, 8'h01: one stuff in byte 0, two data_ready cycles.
        clear_counts();
        pkt_q = '{8'h3F, 8'h01};
        run_packet(-1, 1'b0, -1, 1'b0);
        idle_cycles(2);
        check_int("m3f_len",      m_len,       25);
        check_int("m3f_stuff",    m_es[13],    0);
        check_int("m3f_rdy_n",    m_rdy.size(), 2);
        check_int("m3f_rdy0",     m_rdy[0],    8);
        check_int("m3f_rdy1",     m_rdy[1],    17);
        check_int("p3f_ready_cnt", rdy_seen,   2);

        // Second byte withheld: underrun abort.
        clear_counts();
        pkt_q = '{8'h12, 8'h34};
        run_packet(1, 1'b0, -1, 1'b0);
        idle_cycles(3);
        check_int("uflow_err_cnt",  err_seen,  1);
        check_int("uflow_done_cnt", done_seen, 0);

        // start held through a packet, dropped in IDLE: exactly one packet.
        clear_counts();
        pkt_q = '{8'hA5};
        run_packet(-1, 1'b1, -1, 1'b0);
        idle_cycles(4);
        check_int("hold_one_done_cnt", done_seen, 1);

        // start still high in IDLE: a second packet follows at once.
        clear_counts();
        pkt_q = '{8'h5A};
        run_packet(-1, 1'b1, -1, 1'b0);
        pkt_q = '{8'h7E};
        run_packet(-1, 1'b0, -1, 1'b0);
        idle_cycles(2);
        check_int("hold_two_done_cnt", done_seen, 2);

        // Asynchronous reset in the middle of DATA (line is low there).
        clear_counts();
        pkt_q = '{8'h55, 8'hAA};
        run_packet(-1, 1'b0, 13, 1'b0);
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_bit("arst_line_out", line_out,          1'b1);
        check_bit("arst_line_oe",  line_oe,           1'b0);
        check_bit("arst_busy",     bus_if.busy,       1'b0);
        check_bit("arst_ready",    bus_if.data_ready, 1'b0);
        #1;
        reset = 1'b0;
        pending_done = 1'b0;
        clear_counts();
        pkt_q = '{8'hC3};
        run_packet(-1, 1'b0, -1, 1'b1);
        idle_cycles(2);
        check_int("arst_new_done_cnt", done_seen, 1);

        // Randomized packets, gaps and underruns.
        for (int p = 0; p < 150; p++) begin
            n = int'($urandom_range(4, 1));
            pkt_q.delete();
            for (int i = 0; i < n; i++) begin
                pkt_q.push_back(($urandom_range(2) == 0) ? 8'hFF : 8'($urandom));
            end
            wh = ($urandom_range(4) == 0) ? int'($urandom_range(n - 1)) : -1;
            run_packet(wh, 1'($urandom_range(1)), -1, 1'b0);
            gap = int'($urandom_range(3));
            if (gap > 0) idle_cycles(gap);
        end
        idle_cycles(3);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nrzi_tx_ctrl.md
NRZI_TX_CTRL -- requirements
Module: nrzi_tx_ctrl

Interface
REQ-001 The block SHALL take parameter STUFF_LIMIT, default 6, meaning consecutive encoder-input 1s after which one 0 is inserted.
REQ-002 The block SHALL take parameter EOP_LOW, default 2, meaning cycles the line is forced low at end of packet.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  packet request, sampled only in IDLE.
REQ-006 data_in  input  8  payload byte, sent LSB first.
REQ-007 data_valid  input  1  data_in/data_last are valid.
REQ-008 data_last  input  1  the current byte is the final payload byte.
REQ-009 data_ready  output  1  byte transfer occurs in a cycle where data_valid and data_ready are both high.
REQ-010 line_out  output  1  registered NRZI line level.
REQ-011 line_oe  output  1  line driver enable.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on return to IDLE after a good packet.
REQ-014 err  output  1  one-cycle pulse on underrun abort.

Function
REQ-015 NRZI rule: encoder-input bit 0 toggles line_out, bit 1 holds it; idle level is 1.
REQ-016 Each encoder-input bit presented in cycle n SHALL appear on line_out after the rising edge ending cycle n. One bit is sent per cycle.
REQ-017 The FSM SHALL have states IDLE, SYNC, DATA, STUFF, EOP and TAIL.
REQ-018 IDLE: line_oe=0 and line_out=1. When start=1, the FSM SHALL go to SYNC and set line_oe=1 at the same edge.
REQ-019 SYNC: the FSM SHALL send 8 bits of 8'h80 LSB first (seven 0s, then a 1), then go to DATA.
REQ-020 DATA: the FSM SHALL shift out the held byte with a 3-bit index, bit 0 first.
REQ-021 A ones counter SHALL count consecutive encoder-input 1s, including the final 1 of SYNC.
REQ-022 When the ones counter reaches STUFF_LIMIT, the next cycle SHALL be STUFF: a 0 is sent, the counter clears, and the data index does not advance.
REQ-023 Any 0 bit, data or stuffed, SHALL clear the ones counter.
REQ-024 data_ready SHALL be high only in the cycle that emits the last encoder-input bit before a new byte is needed:
- SYNC bit 7 when no stuff bit is pending.
- Otherwise the DATA bit-7 cycle, or the STUFF cycle that follows it.
- Never for a byte marked data_last.
REQ-025 On a transfer, the byte and its last flag SHALL load into the hold register, and DATA bit 0 of that byte SHALL follow in the next cycle.
REQ-026 Underrun: data_ready=1 with data_valid=0 SHALL set the abort flag, pulse err one cycle later, and go to EOP. No byte is sent.
REQ-027 After the last bit of a data_last byte, plus any stuff bit owed to it, the FSM SHALL go to EOP.
REQ-028 EOP: line_out SHALL be forced to 0 for EOP_LOW cycles, bypassing NRZI.
REQ-029 TAIL: line_out=1 for one cycle. The FSM then goes to IDLE, line_oe drops, and done pulses (suppressed if aborted).
REQ-030 start in any non-IDLE state SHALL be ignored and not queued.
REQ-031 data_valid outside data_ready cycles SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE with line_out=1, line_oe=0, data_ready=0, busy=0, done=0 and err=0.
REQ-033 Reset SHALL clear the ones counter, bit index, hold register and abort flag.
REQ-034 Reset mid-packet SHALL abandon the packet with no done or err pulse.
REQ-035 The first start is honoured on the first rising edge after reset deasserts.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, SYNC_PATTERN=8'h80 and the default STUFF_LIMIT/EOP_LOW constants.
REQ-037 A single sub-module, nrzi_bit_enc, SHALL hold the line register: inputs bit, enable and force_low; output level; reset value 1.

Verification
REQ-038 Reset mid-DATA -> line_out=1 and line_oe=0 immediately (asynchronous), no done, and a new start is accepted normally.
REQ-039 start, one byte 8'h00 with last=1 -> line_oe rises; line_out toggles on each of 7 sync zeros and holds on the sync 1; then 8 toggles, 2 low cycles, 1 high cycle; done pulses at cycle 20; no stuff bit.
REQ-040 Byte 8'hFF with last=1 -> stuff 0 after data bit 4 (sync 1 plus 5 data 1s = 6); bits 5–7 then count 3 with no second stuff; 9 DATA/STUFF cycles.
REQ-041 Bytes 8'h3F, 8'h01 (last=1) -> stuff after bit 4 of byte 0, and after bit 5 no second stuff (count restarts); data_ready is high exactly twice, on the correct cycles.
REQ-042 Second byte withheld at data_ready -> err pulses once, EOP then TAIL follows, no done, busy falls after TAIL.
REQ-043 start held high through a whole packet -> exactly one packet; a second starts only if start is still high in IDLE.
